// File: rtl/dm_arbiter_if.sv
// Port bundle for dm_arbiter: two requester ports with req/ack handshake plus the data-memory side.
interface dm_arbiter_if;
  logic        req0, we0, ack0, err0;
  logic [31:0] addr0, wd0, rd0;
  logic [2:0]  op0;
  logic        req1, we1, ack1, err1;
  logic [31:0] addr1, wd1, rd1;
  logic [2:0]  op1;
  logic        dm_wr, busy;
  logic [31:0] dm_a, dm_wd, dm_rd;
  logic [2:0]  dm_op;

  modport slave (
    input  req0, we0, addr0, wd0, op0,
    input  req1, we1, addr1, wd1, op1,
    input  dm_rd,
    output ack0, err0, rd0, ack1, err1, rd1,
    output dm_wr, dm_a, dm_wd, dm_op, busy
  );

  modport master (
    output req0, we0, addr0, wd0, op0,
    output req1, we1, addr1, wd1, op1,
    output dm_rd,
    input  ack0, err0, rd0, ack1, err1, rd1,
    input  dm_wr, dm_a, dm_wd, dm_op, busy
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port data-memory arbiter: req sampled at T, one ACCESS cycle, ack at T+2; losers wait with req held.
// Fixed priority (port 0) with a HOLD_MAX starvation guard; define DM_ARB_RR_EN for round-robin ties.
module dm_arbiter #(
  parameter int unsigned HOLD_MAX = 4
) (
  input logic          Clk,
  input logic          Rst,
  dm_arbiter_if.slave  bus
);
  localparam logic [2:0] DM_w  = 3'd0;
  localparam logic [2:0] DM_h  = 3'd1;
  localparam logic [2:0] DM_b  = 3'd2;
  localparam logic [2:0] DM_hu = 3'd3;
  localparam logic [2:0] DM_bu = 3'd4;
  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nxt;

  logic        l_port, l_we;
  logic [31:0] l_addr, l_wd;
  logic [2:0]  l_op;
  logic        last_gnt;
  logic [3:0]  hold_cnt;
`ifdef DM_ARB_RR_EN
  logic        rr_ptr;
`endif
  logic        elig0, elig1, gnt_vld, gnt_port, other_elig, aligned;

  always_comb begin
    case (l_op)
      DM_w:        aligned = (l_addr[1:0] == 2'b00);
      DM_h, DM_hu: aligned = ~l_addr[0];
      default:     aligned = 1'b1;
    endcase
  end

  // The port just acked still shows req high in RESP; it only competes if the other port is also asking.
  always_comb begin
    elig0 = bus.req0;
    elig1 = bus.req1;
    if (state == RESP) begin
      if (!l_port && !bus.req1) elig0 = 1'b0;
      if (l_port && !bus.req0)  elig1 = 1'b0;
    end
    gnt_vld  = ((state == IDLE) || (state == RESP)) && (elig0 || elig1);
    gnt_port = elig1;
    if (elig0 && elig1) begin
      if (hold_cnt >= HOLD_LIM) gnt_port = ~last_gnt;
`ifdef DM_ARB_RR_EN
      else gnt_port = rr_ptr;
`else
      else gnt_port = 1'b0;
`endif
    end
    other_elig = gnt_port ? elig0 : elig1;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    bus.dm_wr  = 1'b0;
    bus.dm_a   = 32'd0;
    bus.dm_wd  = 32'd0;
    bus.dm_op  = 3'd0;
    bus.busy   = (state == ACCESS) || (state == RESP);
    case (state)
      IDLE:    if (gnt_vld) state_nxt = ACCESS;
      ACCESS: begin
        state_nxt = RESP;
        bus.dm_wr = l_we && aligned;
        bus.dm_a  = l_addr;
        bus.dm_wd = l_wd;
        bus.dm_op = l_op;
      end
      RESP:    state_nxt = gnt_vld ? ACCESS : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      l_port   <= 1'b0;
      l_we     <= 1'b0;
      l_addr   <= 32'd0;
      l_wd     <= 32'd0;
      l_op     <= 3'd0;
      last_gnt <= 1'b0;
      hold_cnt <= 4'd0;
`ifdef DM_ARB_RR_EN
      rr_ptr   <= 1'b0;
`endif
      bus.ack0 <= 1'b0;
      bus.ack1 <= 1'b0;
      bus.err0 <= 1'b0;
      bus.err1 <= 1'b0;
      bus.rd0  <= 32'd0;
      bus.rd1  <= 32'd0;
    end else begin
      bus.ack0 <= 1'b0;
      bus.ack1 <= 1'b0;
      bus.err0 <= 1'b0;
      bus.err1 <= 1'b0;
      if (gnt_vld) begin
        l_port   <= gnt_port;
        l_we     <= gnt_port ? bus.we1   : bus.we0;
        l_addr   <= gnt_port ? bus.addr1 : bus.addr0;
        l_wd     <= gnt_port ? bus.wd1   : bus.wd0;
        l_op     <= gnt_port ? bus.op1   : bus.op0;
        last_gnt <= gnt_port;
`ifdef DM_ARB_RR_EN
        rr_ptr   <= ~gnt_port;
`endif
        // Counts the current grant, so the guard fires once HOLD_MAX grants in a row have gone out.
        if (!other_elig)                               hold_cnt <= 4'd0;
        else if (state == IDLE || gnt_port != last_gnt) hold_cnt <= 4'd1;
        else if (hold_cnt != 4'hF)                      hold_cnt <= hold_cnt + 4'd1;
      end else if (state == IDLE) begin
        hold_cnt <= 4'd0;
      end
      if (state == ACCESS) begin
        if (l_port) begin
          bus.ack1 <= 1'b1;
          bus.err1 <= ~aligned;
          if (!l_we && aligned) bus.rd1 <= bus.dm_rd;
        end else begin
          bus.ack0 <= 1'b1;
          bus.err0 <= ~aligned;
          if (!l_we && aligned) bus.rd0 <= bus.dm_rd;
        end
      end
    end
  end
endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus random traffic against a byte-array reference memory.
module tb_dm_arbiter;
  localparam logic [2:0] DM_w  = 3'd0;
  localparam logic [2:0] DM_h  = 3'd1;
  localparam logic [2:0] DM_b  = 3'd2;
  localparam logic [2:0] DM_hu = 3'd3;
  localparam logic [2:0] DM_bu = 3'd4;
  localparam int HOLD = 4;

  logic Clk, Rst;
  int   checks = 0;
  int   errors = 0;

  dm_arbiter_if bus();
  dm_arbiter #(.HOLD_MAX(HOLD)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Environment memory seen by the DUT; written mid-cycle so a reset that drops dm_wr suppresses it.
  logic [7:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    forever begin
      @(negedge Clk);
      if (bus.dm_wr) begin
        mem[bus.dm_a[7:0]] = bus.dm_wd[7:0];
        if (bus.dm_op == DM_w || bus.dm_op == DM_h || bus.dm_op == DM_hu)
          mem[bus.dm_a[7:0] + 8'd1] = bus.dm_wd[15:8];
        if (bus.dm_op == DM_w) begin
          mem[bus.dm_a[7:0] + 8'd2] = bus.dm_wd[23:16];
          mem[bus.dm_a[7:0] + 8'd3] = bus.dm_wd[31:24];
        end
      end
    end
  end

  always_comb begin
    logic [7:0] b0, b1, b2, b3;
    b0 = mem[bus.dm_a[7:0]];
    b1 = mem[bus.dm_a[7:0] + 8'd1];
    b2 = mem[bus.dm_a[7:0] + 8'd2];
    b3 = mem[bus.dm_a[7:0] + 8'd3];
    case (bus.dm_op)
      DM_w:    bus.dm_rd = {b3, b2, b1, b0};
      DM_h:    bus.dm_rd = {{16{b1[7]}}, b1, b0};
      DM_hu:   bus.dm_rd = {16'd0, b1, b0};
      DM_b:    bus.dm_rd = {{24{b0[7]}}, b0};
      DM_bu:   bus.dm_rd = {24'd0, b0};
      default: bus.dm_rd = 32'd0;
    endcase
  end

  // Reference model: little-endian byte memory plus last load value per port.
  logic [7:0]  ref_mem [256];
  logic [31:0] exp_rd [2];

  function automatic bit is_aligned(input logic [31:0] a, input logic [2:0] op);
    if (op == DM_w) return a[1:0] == 2'b00;
    if (op == DM_h || op == DM_hu) return a[0] == 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] op);
    int base = int'(a[7:0]);
    int nbytes = (op == DM_w) ? 4 : (op == DM_h || op == DM_hu) ? 2 : 1;
    bit sgn = (op == DM_h || op == DM_b);
    logic [31:0] v = 32'd0;
    for (int k = 0; k < nbytes; k++) v = v | (32'(ref_mem[(base + k) % 256]) << (8 * k));
    if (sgn && v[8 * nbytes - 1]) v = v | (32'hFFFF_FFFF << (8 * nbytes));
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
    int nbytes = (op == DM_w) ? 4 : (op == DM_h || op == DM_hu) ? 2 : 1;
    for (int k = 0; k < nbytes; k++) ref_mem[(int'(a[7:0]) + k) % 256] = d[8 * k +: 8];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input bit p, input bit r, input bit we, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] op);
    if (p) begin
      bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wd1 = d; bus.op1 = op;
    end else begin
      bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wd0 = d; bus.op0 = op;
    end
  endtask

  // Updates the reference for a completed transaction; returns the expected err flag.
  task automatic ref_apply(input bit p, input bit we, input logic [31:0] a,
                           input logic [31:0] d, input logic [2:0] op, output bit err);
    err = !is_aligned(a, op);
    if (!err) begin
      if (we) ref_store(a, d, op);
      else    exp_rd[p] = ref_load(a, op);
    end
  endtask

  task automatic run_one(input string tag, input bit p, input bit we, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] op, input bit drop_early);
    bit err;
    drive(p, 1'b1, we, a, d, op);
    tick();
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    chk({tag, "_dm_wr"}, 32'(bus.dm_wr), 32'(we && is_aligned(a, op)));
    chk({tag, "_dm_a"}, bus.dm_a, a);
    if (drop_early) drive(p, 1'b0, we, a, d, op);
    tick();
    ref_apply(p, we, a, d, op, err);
    chk({tag, "_ack"}, 32'(p ? bus.ack1 : bus.ack0), 32'd1);
    chk({tag, "_err"}, 32'(p ? bus.err1 : bus.err0), 32'(err));
    chk({tag, "_rd"}, p ? bus.rd1 : bus.rd0, exp_rd[p]);
    drive(p, 1'b0, we, a, d, op);
    tick();
    chk({tag, "_ack_end"}, 32'(p ? bus.ack1 : bus.ack0), 32'd0);
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack0"}, 32'(bus.ack0), 32'd0);
    chk({tag, "_ack1"}, 32'(bus.ack1), 32'd0);
    chk({tag, "_err0"}, 32'(bus.err0), 32'd0);
    chk({tag, "_err1"}, 32'(bus.err1), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_rd0"}, bus.rd0, 32'd0);
    chk({tag, "_rd1"}, bus.rd1, 32'd0);
    chk({tag, "_dm_wr"}, 32'(bus.dm_wr), 32'd0);
    chk({tag, "_dm_a"}, bus.dm_a, 32'd0);
    chk({tag, "_dm_wd"}, bus.dm_wd, 32'd0);
    chk({tag, "_dm_op"}, 32'(bus.dm_op), 32'd0);
  endtask

  initial begin
    bit          p, we, err, w, last, rr;
    logic [31:0] a, d;
    logic [2:0]  op;
    int          run, waited;
    bit          pw [2];
    logic [31:0] pa [2], pd [2];
    logic [2:0]  po [2];

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    exp_rd[0] = 32'd0;
    exp_rd[1] = 32'd0;
    Rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    #1 Rst = 1'b1;
    tick();
    tick();
    chk_all_zero("reset");
    Rst = 1'b0;
    tick();

    run_one("st_w10", 1'b0, 1'b1, 32'h10, 32'h1234_5678, DM_w, 1'b0);
    run_one("ld_w10", 1'b0, 1'b0, 32'h10, 32'h0, DM_w, 1'b0);
    chk("ld_w10_val", bus.rd0, 32'h1234_5678);
    run_one("st_b21", 1'b0, 1'b1, 32'h21, 32'h0000_0080, DM_b, 1'b0);
    run_one("ld_b21", 1'b0, 1'b0, 32'h21, 32'h0, DM_b, 1'b0);
    chk("ld_b21_val", bus.rd0, 32'hFFFF_FF80);
    run_one("ld_bu21", 1'b0, 1'b0, 32'h21, 32'h0, DM_bu, 1'b0);
    chk("ld_bu21_val", bus.rd0, 32'h0000_0080);
    run_one("st_mis22", 1'b1, 1'b1, 32'h22, 32'hCAFE_F00D, DM_w, 1'b0);
    run_one("ld_w20", 1'b1, 1'b0, 32'h20, 32'h0, DM_w, 1'b0);
    run_one("ld_mis_h", 1'b1, 1'b0, 32'h23, 32'h0, DM_h, 1'b0);

    // Abort a store with reset while it is in its ACCESS cycle.
    run_one("st_w40", 1'b1, 1'b1, 32'h40, 32'h0BAD_F00D, DM_w, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, DM_w);
    tick();
    chk("rst_mid_busy", 32'(bus.busy), 32'd1);
    #2 Rst = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    tick();
    chk("rst_mid_noack", 32'(bus.ack0), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    Rst = 1'b0;
    exp_rd[0] = 32'd0;
    exp_rd[1] = 32'd0;
    tick();
    run_one("ld_w40", 1'b0, 1'b0, 32'h40, 32'h0, DM_w, 1'b0);
    chk("ld_w40_val", bus.rd0, 32'h0BAD_F00D);

    run_one("early_drop", 1'b0, 1'b0, 32'h10, 32'h0, DM_w, 1'b1);
    tick();
    chk("early_drop_noretry", 32'(bus.busy), 32'd0);

    for (int i = 0; i < 24; i++) begin
      p  = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      a  = 32'h80 + $urandom_range(0, 123);
      d  = $urandom;
      op = 3'($urandom_range(0, 4));
      run_one($sformatf("rand%0d", i), p, we, a, d, op, 1'b0);
    end

    // Contention: both ports always requesting, fresh random work after each ack.
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    exp_rd[0] = 32'd0;
    exp_rd[1] = 32'd0;
    for (int k = 0; k < 2; k++) begin
      pw[k] = 1'($urandom_range(0, 1));
      pa[k] = 32'h80 + $urandom_range(0, 123);
      pd[k] = $urandom;
      po[k] = 3'($urandom_range(0, 4));
      drive(k[0], 1'b1, pw[k], pa[k], pd[k], po[k]);
    end
    last = 1'b0;
    rr   = 1'b0;
    run  = 0;
    for (int g = 0; g < 10; g++) begin
`ifdef DM_ARB_RR_EN
      w  = rr;
      rr = !w;
`else
      w = (run >= HOLD) ? !last : 1'b0;
`endif
      run  = (g > 0 && w == last) ? run + 1 : 1;
      last = w;
      waited = 0;
      do begin
        tick();
        waited++;
      end while (!(bus.ack0 || bus.ack1) && waited < 6);
      if (!(bus.ack0 || bus.ack1)) begin
        chk($sformatf("cont%0d_timeout", g), 32'd0, 32'd1);
        break;
      end
      chk($sformatf("cont%0d_single", g), 32'(bus.ack0 && bus.ack1), 32'd0);
      chk($sformatf("cont%0d_port", g), 32'(bus.ack1), 32'(w));
      ref_apply(w, pw[w], pa[w], pd[w], po[w], err);
      chk($sformatf("cont%0d_err", g), 32'(w ? bus.err1 : bus.err0), 32'(err));
      chk($sformatf("cont%0d_rd", g), w ? bus.rd1 : bus.rd0, exp_rd[w]);
      pw[w] = 1'($urandom_range(0, 1));
      pa[w] = 32'h80 + $urandom_range(0, 123);
      pd[w] = $urandom;
      po[w] = 3'($urandom_range(0, 4));
      drive(w, 1'b1, pw[w], pa[w], pd[w], po[w]);
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    tick();
    tick();
    chk("cont_idle", 32'(bus.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
